// File: rtl/rca_pkg.sv
// Shared types and constants for the byte-serial ripple-carry add sequencer.
package rca_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } st_e;

endpackage

// File: rtl/rca.sv
// Combinational 8-bit ripple-carry adder.
module rca
  import rca_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              cin_i,
  output logic [BYTE_W-1:0] s_o,
  output logic              cout_o
);

  logic [BYTE_W:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[BYTE_W];

endmodule

// File: rtl/rca_mp_sequencer.sv
// Byte-serial multi-precision adder: streams LSB-first byte pairs through one rca,
// chaining the carry between beats and registering each sum byte.
module rca_mp_sequencer
  import rca_pkg::*;
#(
  parameter int unsigned  MAX_BYTES = 4,
  localparam int unsigned IW        = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_a,
  input  logic [BYTE_W-1:0] in_b,
  input  logic              in_cin,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_s,
  output logic [IW-1:0]     out_idx,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_ovf,
  output logic              out_err
);

  localparam logic [IW-1:0] IdxLast = IW'(MAX_BYTES - 1);

  st_e             st_q, st_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            err_q, err_d;

  logic              accept;
  logic              cin_sel;
  logic [BYTE_W-1:0] sum;
  logic              cout;

  logic              out_valid_q, out_valid_d;
  logic [BYTE_W-1:0] out_s_q, out_s_d;
  logic [IW-1:0]     out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              out_cout_q, out_cout_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_err_q, out_err_d;

  rca u_rca (
    .a_i    (in_a),
    .b_i    (in_b),
    .cin_i  (cin_sel),
    .s_o    (sum),
    .cout_o (cout)
  );

  // Control state: packet FSM, chained carry, byte index and sticky overlength flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      carry_q <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next-state: every accepted beat advances the packet; a last beat rearms for a new one.
  always_comb begin
    st_d    = st_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    err_d   = err_q;
    if (accept) begin
      carry_d = cout;
      if (in_last) begin
        st_d  = IDLE;
        idx_d = '0;
        err_d = 1'b0;
      end else begin
        st_d  = BUSY;
        idx_d = idx_q + 1'b1;
        if (idx_q == IdxLast) begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Outputs: handshake, carry mux and the next contents of the one-entry output stage.
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
    // First beat of a packet takes the external carry; later beats chain the stored one.
    cin_sel  = (st_q == IDLE) ? in_cin : carry_q;

    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_s_d     = sum;
      out_idx_d   = idx_q;
      out_last_d  = in_last;
      out_cout_d  = in_last & cout;
      out_ovf_d   = in_last & (in_a[BYTE_W-1] == in_b[BYTE_W-1]) &
                    (sum[BYTE_W-1] != in_a[BYTE_W-1]);
      out_err_d   = in_last & err_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // One-entry output register; data only moves on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_rca_mp_sequencer.sv
// Self-checking bench for rca_mp_sequencer: directed vector table, hand-written
// backpressure/reset sequences, then randomized packets against a whole-packet
// arithmetic model.
module tb_rca_mp_sequencer;

  localparam int unsigned MAXB = 4;
  localparam int unsigned IW   = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic          in_cin;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_s;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_cout;
  logic          out_ovf;
  logic          out_err;

  int checks   = 0;
  int failures = 0;

  rca_mp_sequencer #(
    .MAX_BYTES (MAXB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       last;
    logic [7:0] s;
    logic [1:0] idx;
    logic       cout;
    logic       ovf;
    logic       err;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic [1:0] idx;
    logic       last;
    logic       cout;
    logic       ovf;
    logic       err;
  } exp_t;

  vec_t vecs[12];
  exp_t expq[$];
  bit   drv_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic cin,
                              input logic last, input logic [7:0] s, input logic [1:0] idx,
                              input logic cout, input logic ovf, input logic err);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.last = last;
    v.s = s; v.idx = idx; v.cout = cout; v.ovf = ovf; v.err = err;
    return v;
  endfunction

  // Observed output fields packed {s, idx, last, cout, ovf, err}.
  function automatic logic [31:0] obs();
    return 32'({out_s, out_idx, out_last, out_cout, out_ovf, out_err});
  endfunction

  function automatic logic [31:0] pack(input logic [7:0] s, input logic [1:0] idx,
                                       input logic last, input logic cout, input logic ovf,
                                       input logic err);
    return 32'({s, idx, last, cout, ovf, err});
  endfunction

  // Drive one beat starting at a negedge; returns at the negedge after acceptance.
  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic last);
    int  waitc = 0;
    bit  acc   = 0;
    in_a = a; in_b = b; in_cin = cin; in_last = last; in_valid = 1'b1;
    while (!acc) begin
      #4;
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (!acc) begin
        waitc++;
        if (waitc > 1000) begin
          checks++;
          failures++;
          $display("FAIL drive_timeout: in_ready stayed 0 for %0d cycles", waitc);
          acc = 1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Random stimulus source; expected bytes come from whole-packet integer arithmetic.
  task automatic random_driver();
    for (int p = 0; p < 150; p++) begin
      int unsigned n;
      logic [7:0]  av[5];
      logic [7:0]  bv[5];
      logic        cin;
      logic [63:0] aw, bw, tot;
      n   = $urandom_range(1, 5);
      cin = 1'($urandom);
      aw  = '0;
      bw  = '0;
      for (int k = 0; k < 5; k++) begin
        av[k] = 8'($urandom);
        bv[k] = 8'($urandom);
      end
      // Bias some packets towards carry chains and sign boundaries.
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 5; k++) begin
          av[k] = 8'hFF;
        end
        bv[0] = 8'h01;
      end
      for (int k = 0; k < int'(n); k++) begin
        aw = aw | (64'(av[k]) << (8 * k));
        bw = bw | (64'(bv[k]) << (8 * k));
      end
      tot = aw + bw + 64'(cin);
      for (int k = 0; k < int'(n); k++) begin
        exp_t e;
        bit   lst;
        lst    = (k == int'(n) - 1);
        e.s    = tot[8*k +: 8];
        e.idx  = 2'(k % MAXB);
        e.last = lst;
        e.cout = lst & tot[8*n];
        e.ovf  = lst & (aw[8*n-1] == bw[8*n-1]) & (tot[8*n-1] != aw[8*n-1]);
        e.err  = lst & (n > MAXB);
        expq.push_back(e);
      end
      for (int k = 0; k < int'(n); k++) begin
        logic c;
        c = (k == 0) ? cin : 1'($urandom);
        drive_beat(av[k], bv[k], c, k == int'(n) - 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drv_done = 1;
  endtask

  // Random sink: toggles out_ready, scoreboards each delivered byte and checks holds.
  task automatic random_monitor();
    int          cyc  = 0;
    bit          hold = 0;
    logic [31:0] held = '0;
    while (!(drv_done && expq.size() == 0)) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 9) < 7);
      #4;
      if (hold && out_valid) begin
        check("hold_stable", obs(), held);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'(0));
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("rand_byte", obs(), pack(e.s, e.idx, e.last, e.cout, e.ovf, e.err));
        end
      end
      hold = out_valid && !out_ready;
      held = obs();
      cyc++;
      if (cyc > 20000) begin
        checks++;
        failures++;
        $display("FAIL monitor_timeout: %0d bytes still pending", expq.size());
        break;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    vecs[0]  = mk(8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 2'd1, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(8'h01, 8'h01, 1'b1, 1'b1, 8'h03, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 2'd0, 1'b0, 1'b1, 1'b0);
    vecs[5]  = mk(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
    vecs[11] = mk(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 2'd0, 1'b0, 1'b0, 1'b0);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_fields", obs(), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Table: one beat per cycle, out_ready high, outputs checked 1 cycle later.
    for (int i = 0; i < 12; i++) begin
      in_a = vecs[i].a; in_b = vecs[i].b; in_cin = vecs[i].cin; in_last = vecs[i].last;
      in_valid = 1'b1;
      #4;
      check("tbl_in_ready", 32'(in_ready), 32'(1));
      @(posedge clk);
      #1;
      check("tbl_out_valid", 32'(out_valid), 32'(1));
      check($sformatf("tbl_vec%0d", i), obs(),
            pack(vecs[i].s, vecs[i].idx, vecs[i].last, vecs[i].cout, vecs[i].ovf,
                 vecs[i].err));
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Backpressure: first beat lands, second stalls for 3 cycles, then both delivered.
    out_ready = 1'b0;
    in_a = 8'h10; in_b = 8'h20; in_cin = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_a = 8'h05; in_b = 8'h06;
    for (int k = 0; k < 3; k++) begin
      #4;
      check("bp_in_ready_low", 32'(in_ready), 32'(0));
      check("bp_hold", obs(), pack(8'h30, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #4;
    check("bp_release_first", {out_valid, obs()}, {1'b1, pack(8'h30, 2'd0, 1'b1, 1'b0, 1'b0,
                                                              1'b0)});
    check("bp_release_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    check("bp_second", {out_valid, obs()}, {1'b1, pack(8'h0B, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0)});
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_drain", 32'(out_valid), 32'(0));
    @(negedge clk);

    // Reset mid-packet: a carry is pending when reset hits; it must not leak.
    in_a = 8'hFF; in_b = 8'hFF; in_cin = 1'b1; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("mid_beat0", {out_valid, out_s}, {1'b1, 8'hFF});
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_a = 8'h02; in_b = 8'h03; in_cin = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("mid_new_pkt", {out_valid, obs()}, {1'b1, pack(8'h05, 2'd0, 1'b1, 1'b0, 1'b0,
                                                         1'b0)});
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);

    // Randomized traffic with random gaps and backpressure.
    fork
      random_driver();
      random_monitor();
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rca_mp_sequencer.md
# rca_mp_sequencer

Byte-serial multi-precision add sequencer wrapped around the team's combinational 8-bit ripple-carry adder (`rca`). It accepts operand byte pairs least-significant byte first over a valid/ready stream and feeds each pair to the `rca` instance. The carry out of each byte is held in a register and fed into the next byte. Each sum byte is registered into a one-entry output stage, so operands of any length flow through a single 8-bit adder at one byte per cycle.

## Interface
Parameters:
- `MAX_BYTES`, default 4: longest legal packet length in bytes. Sets the index counter width `IW = $clog2(MAX_BYTES)`, minimum 1.

Ports:
- `clk`, input, 1: the single clock; rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: an operand byte pair is present.
- `in_ready`, output, 1: the block accepts the byte pair this cycle.
- `in_a`, input, 8: operand A byte.
- `in_b`, input, 8: operand B byte.
- `in_cin`, input, 1: packet carry-in. Sampled on the first beat of a packet only.
- `in_last`, input, 1: marks the most-significant byte of the packet.
- `out_valid`, output, 1: a result byte is present.
- `out_ready`, input, 1: downstream accepts the result byte.
- `out_s`, output, 8: sum byte.
- `out_idx`, output, IW: byte position within the packet, starting at 0.
- `out_last`, output, 1: this is the final byte of the packet.
- `out_cout`, output, 1: final carry out. Meaningful only when `out_last` is 1; otherwise 0.
- `out_ovf`, output, 1: two's-complement overflow of the whole packet. Meaningful only when `out_last` is 1; otherwise 0.
- `out_err`, output, 1: the packet exceeded `MAX_BYTES`. Asserted only when `out_last` is 1.

## Operation
- Acceptance: a beat is accepted when `in_valid && in_ready`.
  - `in_ready = !out_valid || out_ready`. This gives full throughput and no combinational path from `in_valid` to `in_ready`.
- State machine, `st`:
  - IDLE: an accepted beat uses `in_cin` as the adder carry-in. If `in_last` is 0, go to BUSY; otherwise stay in IDLE.
  - BUSY: an accepted beat uses `carry_q` as the adder carry-in. If `in_last` is 1, go to IDLE.
  - No beat accepted: state and `carry_q` hold.
- On every accepted beat:
  - `carry_q` is loaded with the `rca` cout.
  - The output register is loaded with `s`, `idx_q`, `in_last`, cout, the overflow value and the error value.
  - Overflow is `(a[7]==b[7]) && (s[7]!=a[7])`, computed on the last beat.
- Index counter `idx_q`:
  - Reset to 0 in IDLE.
  - Increments after each non-last accepted beat; wraps modulo `2^IW`.
  - The sticky flag `err_q` sets when a non-last beat is accepted while `idx_q == MAX_BYTES-1`.
  - Both clear after the last beat.
- Output register:
  - An accepted beat sets `out_valid`.
  - A cycle with `out_ready` high and no accepted beat clears `out_valid`.
  - When both happen in the same cycle, the new beat replaces the old one and `out_valid` stays 1.
  - While `out_valid && !out_ready`, all `out_*` signals hold stable.
- Reset values: `out_valid`=0, `out_s`=0, `out_idx`=0, `out_last`=0, `out_cout`=0, `out_ovf`=0, `out_err`=0, `carry_q`=0, `idx_q`=0, `err_q`=0, `st`=IDLE.
  - `in_ready` is 1 out of reset.
- Reset mid-packet: the partial packet is discarded with no last beat emitted. The next accepted beat is treated as the first byte of a new packet.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on `out_*` after edge N.
- Throughput is 1 byte per cycle while `out_ready` is held high.
- The adder path is combinational from `in_a`, `in_b` and the carry mux to the output register. It is 8 ripple stages and must close within one clock period.
- Back-to-back packets: after a last beat, the first beat of the next packet is accepted on the very next cycle and uses the new `in_cin`.

## Structure
- A shared package `rca_pkg` holds:
  - the `st_e` enum {IDLE, BUSY};
  - `BYTE_W = 8`.
- One sub-module: the existing `rca` (8-bit ripple-carry adder) is instantiated unmodified as the datapath.
- Control, the carry register and the output register live in this module.

## Test plan
- Single-byte packet: a=0x01, b=0x00, cin=0, last=1 → s=0x01, idx=0, cout=0, ovf=0, one cycle later.
- Two-byte packet 0x00FF + 0x0001, cin=0:
  - beat 0 (0xFF, 0x01) → s=0x00, idx=0;
  - beat 1 (0x00, 0x00, last) → s=0x01, idx=1, cout=0.
- Carry-in and overflow:
  - 0x01 + 0x01 with cin=1 → s=0x03.
  - 0x7F + 0x01 with cin=0 → s=0x80, ovf=1, cout=0.
  - 0xFF + 0x01 → s=0x00, cout=1, ovf=0.
- Backpressure:
  - Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and `out_*` stable.
  - Then release → bytes are delivered in order with none lost or duplicated.
- Overlength and recovery:
  - With `MAX_BYTES`=4, send a 5-byte packet → `out_err`=1 on the last byte only.
  - The following 1-byte packet → `out_err`=0.
- Reset mid-packet:
  - Assert `rst_n`=0 after beat 0 of a 2-byte packet → `out_valid`=0 immediately.
  - After release, a new packet 0x02 + 0x03 with cin=0 → s=0x05, idx=0, with no stale carry.
